// File: rtl/syn_lb_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : syn_lb_router_pkg
//  Brief    : Shared constants, FSM state type and helpers for the LB router
//  Revision : 1.0 - initial release
// ============================================================================
package syn_lb_router_pkg;

  // Read data returned on any errored read response
  localparam logic [31:0] LB_ERR_DATA = 32'hDEAD_C0DE;

  typedef enum logic [1:0] {
    LB_IDLE  = 2'd0,
    LB_ISSUE = 2'd1,
    LB_WAIT  = 2'd2,
    LB_RESP  = 2'd3
  } lb_rtr_state_t;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/syn_lb_router_if.sv
`default_nettype none
// ============================================================================
//  Module   : syn_lb_router_if
//  Brief    : Local-bus master side and fan-out slave side of the LB router
//  Revision : 1.0 - initial release
// ============================================================================
interface syn_lb_router_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 12,
  parameter int CODE_W     = 4,
  parameter int DATA_W     = 32
);
  // master side
  logic                         mst_rd_en;
  logic                         mst_wr_en;
  logic [ADDR_W-1:0]            mst_addr;
  logic [DATA_W-1:0]            mst_wr_data;
  logic                         mst_wr_valid;
  logic                         mst_rd_valid;
  logic [DATA_W-1:0]            mst_rd_data;
  logic                         mst_err;
  // slave side
  logic [NUM_SLAVES-1:0]        slv_rd_en;
  logic [NUM_SLAVES-1:0]        slv_wr_en;
  logic [ADDR_W-CODE_W-1:0]     slv_addr;
  logic [DATA_W-1:0]            slv_wr_data;
  logic [NUM_SLAVES-1:0]        slv_wr_valid;
  logic [NUM_SLAVES-1:0]        slv_rd_valid;
  logic [NUM_SLAVES*DATA_W-1:0] slv_rd_data;

  // The bus master issuing requests
  modport master (
    output mst_rd_en, mst_wr_en, mst_addr, mst_wr_data,
    input  mst_wr_valid, mst_rd_valid, mst_rd_data, mst_err
  );

  // The population of slaves behind the router
  modport slave (
    input  slv_rd_en, slv_wr_en, slv_addr, slv_wr_data,
    output slv_wr_valid, slv_rd_valid, slv_rd_data
  );

  // The router itself, sitting between the two
  modport router (
    input  mst_rd_en, mst_wr_en, mst_addr, mst_wr_data,
    output mst_wr_valid, mst_rd_valid, mst_rd_data, mst_err,
    output slv_rd_en, slv_wr_en, slv_addr, slv_wr_data,
    input  slv_wr_valid, slv_rd_valid, slv_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/syn_lb_rst_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : syn_lb_rst_pulse_gen
//  Brief    : Loadable down-counter producing an active-low reset pulse of
//             PULSE_W cycles, starting the cycle after load
//  Revision : 1.0 - initial release
// ============================================================================
module syn_lb_rst_pulse_gen #(
  parameter int PULSE_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic rst_l
);
  localparam int               CNT_W    = $clog2(PULSE_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on request (also while a pulse is running), else count down to 0
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CNT_LOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Global reset forces the output low without waiting for a clock
  assign rst_l = rst_n & (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/syn_lb_router.sv
`default_nettype none
// ============================================================================
//  Module   : syn_lb_router
//  Brief    : One LB master to NUM_SLAVES slaves, single outstanding request,
//             slave timeout, decode errors, soft-reset pulses, drop counter
//  Revision : 1.0 - initial release
// ============================================================================
module syn_lb_router
  import syn_lb_router_pkg::*;
#(
  parameter int                          NUM_SLAVES     = 4,
  parameter int                          ADDR_W         = 12,
  parameter int                          CODE_W         = 4,
  parameter int                          DATA_W         = 32,
  parameter int                          TIMEOUT_CYCLES = 64,
  parameter logic [ADDR_W-CODE_W-1:0]    RST_REG_ADDR   = 8'hFF,
  parameter int                          RST_PULSE_W    = 4
) (
  input  logic                  clk_ir,
  input  logic                  rst_sync_l,
  syn_lb_router_if.router       bus,
  output logic [7:0]            drop_cnt,
  output logic [NUM_SLAVES-1:0] slv_rst_l
);
  localparam int                LOC_W    = ADDR_W - CODE_W;
  localparam int                TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(LB_ERR_DATA);
  localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  lb_rtr_state_t         state_q, state_d;
  logic [LOC_W-1:0]      addr_q, addr_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [7:0]            drop_q, drop_d;

  logic                  req;
  logic [CODE_W-1:0]     req_code;
  logic [LOC_W-1:0]      req_loc;
  logic                  code_ok;
  logic [NUM_SLAVES-1:0] code_oh;
  logic [NUM_SLAVES-1:0] rst_load;
  logic                  sel_wr_vld;
  logic                  sel_rd_vld;
  logic [DATA_W-1:0]     sel_rd_data;

  assign req      = bus.mst_rd_en | bus.mst_wr_en;
  assign req_code = bus.mst_addr[ADDR_W-1 -: CODE_W];
  assign req_loc  = bus.mst_addr[LOC_W-1:0];
  assign code_ok  = (32'(req_code) < 32'(NUM_SLAVES));
  assign code_oh  = NUM_SLAVES'(1) << code_q;

  // Pick the ack/data of the slave owning the outstanding request
  always_comb begin
    sel_wr_vld  = 1'b0;
    sel_rd_vld  = 1'b0;
    sel_rd_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (code_q == CODE_W'(i)) begin
        sel_wr_vld  = bus.slv_wr_valid[i];
        sel_rd_vld  = bus.slv_rd_valid[i];
        sel_rd_data = bus.slv_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state, request capture, timeout and drop accounting
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    code_d    = code_q;
    wr_d      = wr_q;
    err_d     = err_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    to_cnt_d  = to_cnt_q;
    drop_d    = drop_q;
    rst_load  = '0;

    // Only one request may be outstanding; anything arriving meanwhile is lost
    if (state_q != LB_IDLE && req)
      drop_d = sat_inc8(drop_q);

    case (state_q)
      LB_IDLE: begin
        if (req) begin
          addr_d    = req_loc;
          code_d    = req_code;
          wr_d      = bus.mst_wr_en & ~bus.mst_rd_en;  // conflicting request answers as a read
          wr_data_d = bus.mst_wr_data;
          err_d     = 1'b0;
          if (bus.mst_rd_en && bus.mst_wr_en) begin
            err_d     = 1'b1;
            rd_data_d = ERR_DATA;
            state_d   = LB_RESP;
          end else if (!code_ok) begin
            err_d   = 1'b1;
            state_d = LB_RESP;
            if (!bus.mst_wr_en)
              rd_data_d = ERR_DATA;
          end else if (bus.mst_wr_en && req_loc == RST_REG_ADDR) begin
            rst_load = NUM_SLAVES'(1) << req_code;
            state_d  = LB_RESP;
          end else begin
            state_d = LB_ISSUE;
          end
        end
      end
      LB_ISSUE: begin
        to_cnt_d = '0;
        state_d  = LB_WAIT;
      end
      LB_WAIT: begin
        if (wr_q ? sel_wr_vld : sel_rd_vld) begin
          err_d   = 1'b0;
          state_d = LB_RESP;
          if (!wr_q)
            rd_data_d = sel_rd_data;
        end else begin
          // Count WAIT cycles; leaving on the cycle the count hits the limit
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_LIMIT) begin
            err_d   = 1'b1;
            state_d = LB_RESP;
            if (!wr_q)
              rd_data_d = ERR_DATA;
          end
        end
      end
      LB_RESP: begin
        state_d = LB_IDLE;
      end
      default: begin
        state_d = LB_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      state_q   <= LB_IDLE;
      addr_q    <= '0;
      code_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      to_cnt_q  <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      code_q    <= code_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      to_cnt_q  <= to_cnt_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.mst_rd_valid = (state_q == LB_RESP) && !wr_q;
  assign bus.mst_wr_valid = (state_q == LB_RESP) && wr_q;
  assign bus.mst_err      = (state_q == LB_RESP) && err_q;
  assign bus.mst_rd_data  = rd_data_q;
  assign bus.slv_rd_en    = (state_q == LB_ISSUE && !wr_q) ? code_oh : '0;
  assign bus.slv_wr_en    = (state_q == LB_ISSUE &&  wr_q) ? code_oh : '0;
  assign bus.slv_addr     = addr_q;
  assign bus.slv_wr_data  = wr_data_q;
  assign drop_cnt         = drop_q;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_rst_pulse
    syn_lb_rst_pulse_gen #(
      .PULSE_W (RST_PULSE_W)
    ) u_rst_pulse (
      .clk   (clk_ir),
      .rst_n (rst_sync_l),
      .load  (rst_load[g]),
      .rst_l (slv_rst_l[g])
    );
  end

endmodule
`default_nettype wire

// File: doc/syn_lb_router.md
Name: syn_lb_router

Overview:
Parametrised local-bus router for the visual-cortex and other top levels. Routes one LB master to NUM_SLAVES slaves, decoding the slave from the upper CODE_W address bits. Adds features the fixed two-way decoder lacks:
- registered request and response
- single-outstanding tracking
- slave timeout with error response
- decode-error response
- per-slave soft-reset pulse generation on a write to a reserved register
- dropped-request counter

Parameters:
NUM_SLAVES, 4, number of slave ports (1..16, at most 2**CODE_W)
ADDR_W, 12, master address width
CODE_W, 4, block-code width, taken from mst_addr[ADDR_W-1 -: CODE_W]
DATA_W, 32, data width
TIMEOUT_CYCLES, 64, cycles in WAIT with no slave response before an error response
RST_REG_ADDR, 8'hFF, slave-local address that triggers a soft reset; width ADDR_W-CODE_W
RST_PULSE_W, 4, soft-reset low-pulse length in cycles

Ports:
clk_ir  in  1  clock
rst_sync_l  in  1  asynchronous active-low reset
mst_rd_en  in  1  master read request pulse
mst_wr_en  in  1  master write request pulse
mst_addr  in  ADDR_W  master address
mst_wr_data  in  DATA_W  master write data
mst_wr_valid  out  1  write-complete pulse
mst_rd_valid  out  1  read-data-valid pulse
mst_rd_data  out  DATA_W  read data
mst_err  out  1  error flag, qualifies mst_*_valid
drop_cnt  out  8  saturating count of requests dropped while busy
slv_rd_en  out  NUM_SLAVES  per-slave read pulse
slv_wr_en  out  NUM_SLAVES  per-slave write pulse
slv_addr  out  ADDR_W-CODE_W  slave-local address
slv_wr_data  out  DATA_W  write data to slaves
slv_wr_valid  in  NUM_SLAVES  per-slave write ack
slv_rd_valid  in  NUM_SLAVES  per-slave read valid
slv_rd_data  in  NUM_SLAVES*DATA_W  packed read data; slave i occupies [i*DATA_W +: DATA_W]
slv_rst_l  out  NUM_SLAVES  per-slave active-low reset

Behaviour:
- Reset values (rst_sync_l low, asynchronous): all outputs 0 except slv_rst_l, which is forced all-0 combinationally. FSM enters IDLE; counters clear.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: a request is mst_rd_en or mst_wr_en high. On a request, register addr, wr_data, direction and code.
  - Both mst_rd_en and mst_wr_en high: error. Go to RESP with err=1.
  - code >= NUM_SLAVES: decode error. Go to RESP with err=1.
  - Write with local address == RST_REG_ADDR to a valid code: load that slave's pulse counter. Go to RESP with err=0; the write is not forwarded.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): drive slv_rd_en[code] or slv_wr_en[code] high, plus slv_addr and slv_wr_data. Clear the timeout counter. Go to WAIT.
- WAIT:
  - On the selected slave's slv_rd_valid/slv_wr_valid (matching direction), capture slv_rd_data[code] and go to RESP with err=0.
  - Valids from non-selected slaves, or of the wrong direction, are ignored.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with err=1.
- RESP (1 cycle): pulse mst_rd_valid or mst_wr_valid according to the captured direction, with mst_err. Go to IDLE.
  - On error, mst_rd_data = LB_ERR_DATA (32'hDEAD_C0DE, truncated/zero-extended to DATA_W).
  - On a non-read response, mst_rd_data holds its previous value.
- Latency: request at cycle 0 → slave enable at cycle 1. Slave valid at cycle k → master valid at cycle k+1. Decode-error and soft-reset responses arrive at cycle 1.
- Outside RESP, mst_*_valid and mst_err are 0. All slv_*_en are 0 outside ISSUE.
- A request arriving in any state other than IDLE is dropped. drop_cnt increments and saturates at 255.
- A late slave valid arriving after a timeout, while in RESP or IDLE, is ignored.
- Soft reset:
  - slv_rst_l[i] = rst_sync_l & (pulse_cnt[i]==0).
  - pulse_cnt[i] decrements each cycle while non-zero, giving exactly RST_PULSE_W low cycles starting the cycle after the request.
  - Re-triggering during a pulse reloads RST_PULSE_W.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- syn_global_pkg: LB_ERR_DATA.
- syn_gpu_pkg (or a shared LB package): the FSM state typedef lb_rtr_state_t.
- Sub-module syn_lb_rst_pulse_gen: a loadable down-counter with active-low output. Instantiated NUM_SLAVES times in a generate loop.

Test Plan:
- Read to code 2, addr 0x2_10; slave 2 returns 32'h1234_5678 three cycles after slv_rd_en → slv_rd_en=4'b0100 at cycle 1; mst_rd_valid with data 32'h1234_5678 and err=0 at cycle 5.
- Write to code 7 with NUM_SLAVES=4 → no slv_wr_en; mst_wr_valid=1 and mst_err=1 at cycle 1.
- Read to code 1 with slave silent → mst_rd_valid with err=1 and data 32'hDEAD_C0DE exactly TIMEOUT_CYCLES+2 cycles after the request; a late slv_rd_valid[1] produces no second response.
- Write to 0x3_FF → slv_rst_l[3] low for exactly 4 cycles, other bits stay high; mst_wr_valid=1 with err=0 at cycle 1; slv_wr_en stays 0.
- Issue 3 requests while in WAIT → all dropped, drop_cnt=3; then 300 dropped requests → drop_cnt=255.
- Assert rst_sync_l low in mid-WAIT → all outputs 0 and slv_rst_l=0 immediately; after release the FSM is in IDLE and the next read completes normally.
